// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps at most one instruction-memory
// request in flight and hands each fetched word with its PC to decode.
module fetch_unit #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    INSTR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   branchTaken,
  input  logic [ADDR_WIDTH-1:0]  branchTarget,
  output logic                   imemReqValid,
  input  logic                   imemReqReady,
  output logic [ADDR_WIDTH-1:0]  imemAddr,
  input  logic                   imemRespValid,
  input  logic [INSTR_WIDTH-1:0] imemRespData,
  output logic                   instrValid,
  output logic [INSTR_WIDTH-1:0] instrOut,
  output logic [ADDR_WIDTH-1:0]  instrPc,
  input  logic                   instrReady,
  output logic [2:0]             o_dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; the source keeps valid and payload stable until that edge.

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_HOLD = 3'd3,
    S_DROP = 3'd4
  } state_t;

  state_t                 r_state;
  state_t                 w_next_state;
  logic [ADDR_WIDTH-1:0]  r_pc;
  logic [ADDR_WIDTH-1:0]  r_req_pc;
  logic                   r_instr_valid;
  logic [INSTR_WIDTH-1:0] r_instr;
  logic [ADDR_WIDTH-1:0]  r_instr_pc;

  logic [ADDR_WIDTH-1:0]  w_target;
  logic                   w_redirect;
  logic                   w_req_fire;
  logic                   w_capture;
  logic                   w_release;
  logic [1:0]             w_unused_tgt_lo;

  assign w_target        = {branchTarget[ADDR_WIDTH-1:2], 2'b00};
  assign w_unused_tgt_lo = branchTarget[1:0];
  // IDLE lasts a single cycle after reset; a redirect there has nothing to steer.
  assign w_redirect      = branchTaken && (r_state != S_IDLE);
  assign w_req_fire      = imemReqValid && imemReqReady;
  assign w_capture       = (r_state == S_WAIT) && !branchTaken && imemRespValid;
  assign w_release       = (r_state == S_HOLD) && (branchTaken || instrReady);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: w_next_state = S_REQ;
      S_REQ: begin
        if (!branchTaken && imemReqReady) w_next_state = S_WAIT;
      end
      S_WAIT: begin
        if (branchTaken) w_next_state = imemRespValid ? S_REQ : S_DROP;
        else if (imemRespValid) w_next_state = S_HOLD;
      end
      S_HOLD: begin
        if (branchTaken || instrReady) w_next_state = S_REQ;
      end
      S_DROP: begin
        // The response belongs to the abandoned path; it only ends the wait.
        if (imemRespValid) w_next_state = S_REQ;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    imemReqValid = (r_state == S_REQ) && !branchTaken;
    imemAddr     = r_pc;
    o_dbg_state  = r_state;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc          <= RESET_PC;
      r_req_pc      <= '0;
      r_instr_valid <= 1'b0;
      r_instr       <= '0;
      r_instr_pc    <= '0;
    end else begin
      if (w_redirect) begin
        r_pc <= w_target;
      end else if (w_req_fire) begin
        r_req_pc <= r_pc;
        r_pc     <= r_pc + ADDR_WIDTH'(4);
      end
      if (w_capture) begin
        r_instr       <= imemRespData;
        r_instr_pc    <= r_req_pc;
        r_instr_valid <= 1'b1;
      end else if (w_release) begin
        r_instr_valid <= 1'b0;
      end
    end
  end

  assign instrValid = r_instr_valid;
  assign instrOut   = r_instr;
  assign instrPc    = r_instr_pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, hand-written redirect/wrap/reset
// sequences, then random traffic against a transaction-level fetch model.
module tb_fetch_unit;

  typedef struct {
    logic        rst;
    logic        rq_rdy;
    logic        rsp_v;
    logic [31:0] rsp_d;
    logic        ir;
    logic        e_rv;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_io;
    logic [31:0] e_ipc;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, br, rq_rdy, rsp_v, ir;
  logic [31:0] tgt, rsp_d;
  logic        reqv, iv;
  logic [31:0] addr, io, ipc;
  logic [2:0]  dbg_unused;
  logic        w_reqv, w_iv;
  logic [31:0] w_addr, w_io, w_ipc;
  logic [2:0]  w_dbg_unused;

  int          n_checks = 0;
  int          n_fail   = 0;
  vec_t        vecs[22];
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  fetch_unit #(.ADDR_WIDTH(32), .INSTR_WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(rst), .branchTaken(br), .branchTarget(tgt),
    .imemReqValid(reqv), .imemReqReady(rq_rdy), .imemAddr(addr),
    .imemRespValid(rsp_v), .imemRespData(rsp_d),
    .instrValid(iv), .instrOut(io), .instrPc(ipc), .instrReady(ir),
    .o_dbg_state(dbg_unused)
  );

  fetch_unit #(.ADDR_WIDTH(32), .INSTR_WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .reset(rst), .branchTaken(br), .branchTarget(tgt),
    .imemReqValid(w_reqv), .imemReqReady(rq_rdy), .imemAddr(w_addr),
    .imemRespValid(rsp_v), .imemRespData(rsp_d),
    .instrValid(w_iv), .instrOut(w_io), .instrPc(w_ipc), .instrReady(ir),
    .o_dbg_state(w_dbg_unused)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  function automatic vec_t row(input logic r, input logic q, input logic v, input logic [31:0] d,
                               input logic i, input logic erv, input logic [31:0] ea,
                               input logic eiv, input logic [31:0] eio, input logic [31:0] eipc);
    vec_t t;
    t.rst = r; t.rq_rdy = q; t.rsp_v = v; t.rsp_d = d; t.ir = i;
    t.e_rv = erv; t.e_addr = ea; t.e_iv = eiv; t.e_io = eio; t.e_ipc = eipc;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drv(input logic r, input logic b, input logic [31:0] t, input logic q,
                     input logic v, input logic [31:0] d, input logic i);
    rst = r; br = b; tgt = t; rq_rdy = q; rsp_v = v; rsp_d = d; ir = i;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drv(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    tick();
  endtask

  task automatic run_table();
    localparam logic [31:0] D0 = 32'h0000_0013;
    localparam logic [31:0] D1 = 32'h0010_0093;
    localparam logic [31:0] D2 = 32'h0020_8113;
    localparam logic [31:0] JK = 32'hBAD0_BAD0;
    vecs[0]  = row(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    vecs[1]  = row(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    vecs[2]  = row(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
    vecs[3]  = row(1'b0, 1'b1, 1'b1, D0,    1'b1, 1'b0, 32'h4, 1'b0, 32'h0, 32'h0);
    vecs[4]  = row(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h4, 1'b1, D0,    32'h0);
    vecs[5]  = row(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h4, 1'b0, D0,    32'h0);
    vecs[6]  = row(1'b0, 1'b1, 1'b1, D1,    1'b0, 1'b0, 32'h8, 1'b0, D0,    32'h0);
    for (int k = 7; k <= 11; k++)
      vecs[k] = row(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h8, 1'b1, D1, 32'h4);
    vecs[12] = row(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h8, 1'b1, D1,    32'h4);
    for (int k = 13; k <= 15; k++)
      vecs[k] = row(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h8, 1'b0, D1, 32'h4);
    vecs[16] = row(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h8, 1'b0, D1,    32'h4);
    vecs[17] = row(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'hC, 1'b0, D1,    32'h4);
    vecs[18] = row(1'b0, 1'b1, 1'b1, D2,    1'b1, 1'b0, 32'hC, 1'b0, D1,    32'h4);
    vecs[19] = row(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'hC, 1'b1, D2,    32'h8);
    vecs[20] = row(1'b0, 1'b0, 1'b1, JK,    1'b1, 1'b1, 32'hC, 1'b0, D2,    32'h8);
    vecs[21] = row(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'hC, 1'b0, D2,    32'h8);
    for (int i = 0; i < 22; i++) begin
      drv(vecs[i].rst, 1'b0, 32'h0, vecs[i].rq_rdy, vecs[i].rsp_v, vecs[i].rsp_d, vecs[i].ir);
      @(negedge clk);
      chk($sformatf("vec%0d_reqvalid", i), 32'(reqv), 32'(vecs[i].e_rv));
      chk($sformatf("vec%0d_addr", i), addr, vecs[i].e_addr);
      chk($sformatf("vec%0d_instrvalid", i), 32'(iv), 32'(vecs[i].e_iv));
      chk($sformatf("vec%0d_instrout", i), io, vecs[i].e_io);
      chk($sformatf("vec%0d_instrpc", i), ipc, vecs[i].e_ipc);
      tick();
    end
  endtask

  task automatic redirect_seq();
    do_reset();
    drv(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    @(negedge clk); chk("rd_idle_noreq", 32'(reqv), 32'h0); tick();
    drv(1'b0, 1'b1, 32'h0000_000B, 1'b1, 1'b0, 32'h0, 1'b0);
    @(negedge clk); chk("rd_req_branch_masks", 32'(reqv), 32'h0); tick();
    drv(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    @(negedge clk); chk("rd_req_valid", 32'(reqv), 32'h1); chk("rd_req_addr8", addr, 32'h8); tick();
    drv(1'b0, 1'b1, 32'h0000_0103, 1'b0, 1'b0, 32'h0, 1'b1);
    @(negedge clk); chk("rd_wait_iv", 32'(iv), 32'h0); tick();
    drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1);
    @(negedge clk); chk("rd_drop_iv", 32'(iv), 32'h0); chk("rd_drop_noreq", 32'(reqv), 32'h0); tick();
    drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    @(negedge clk); chk("rd_dropped_iv", 32'(iv), 32'h0); chk("rd_target_addr", addr, 32'h100);
    chk("rd_target_reqv", 32'(reqv), 32'h1); tick();
    drv(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    @(negedge clk); chk("rd_req_0x100", addr, 32'h100); tick();
    drv(1'b0, 1'b1, 32'h0000_0200, 1'b1, 1'b1, 32'h1111_1111, 1'b1);
    @(negedge clk); chk("rd_coinc_noreq", 32'(reqv), 32'h0); tick();
    drv(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    @(negedge clk); chk("rd_coinc_iv", 32'(iv), 32'h0); chk("rd_coinc_addr", addr, 32'h200);
    chk("rd_coinc_reqv", 32'(reqv), 32'h1); tick();
    drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h2222_2222, 1'b1);
    @(negedge clk); tick();
    drv(1'b0, 1'b1, 32'h0000_0300, 1'b0, 1'b0, 32'h0, 1'b1);
    @(negedge clk); chk("rd_hold_iv", 32'(iv), 32'h1); chk("rd_hold_io", io, 32'h2222_2222);
    chk("rd_hold_pc", ipc, 32'h200); tick();
    drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    @(negedge clk); chk("rd_flush_iv", 32'(iv), 32'h0); chk("rd_flush_addr", addr, 32'h300);
    chk("rd_flush_reqv", 32'(reqv), 32'h1); tick();
  endtask

  task automatic wrap_seq();
    do_reset();
    @(negedge clk); chk("wr_rst_reqv", 32'(w_reqv), 32'h0); chk("wr_rst_addr", w_addr, 32'hFFFF_FFFC);
    chk("wr_rst_iv", 32'(w_iv), 32'h0); tick();
    drv(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    @(negedge clk); chk("wr_idle_reqv", 32'(w_reqv), 32'h0); tick();
    @(negedge clk); chk("wr_req1_reqv", 32'(w_reqv), 32'h1); chk("wr_req1_addr", w_addr, 32'hFFFF_FFFC); tick();
    drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h3333_3333, 1'b1);
    @(negedge clk); chk("wr_wrapped_pc", w_addr, 32'h0); tick();
    drv(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    @(negedge clk); chk("wr_hold_iv", 32'(w_iv), 32'h1); chk("wr_hold_io", w_io, 32'h3333_3333);
    chk("wr_hold_pc", w_ipc, 32'hFFFF_FFFC); tick();
    @(negedge clk); chk("wr_req2_reqv", 32'(w_reqv), 32'h1); chk("wr_req2_addr", w_addr, 32'h0); tick();
    drv(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    @(negedge clk); tick();
    drv(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h4444_4444, 1'b1);
    @(negedge clk); chk("wr_after_rst_iv", 32'(w_iv), 32'h0); chk("wr_after_rst_reqv", 32'(w_reqv), 32'h0);
    chk("wr_after_rst_addr", w_addr, 32'hFFFF_FFFC); tick();
    drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    @(negedge clk); chk("wr_restart_reqv", 32'(w_reqv), 32'h1); chk("wr_restart_addr", w_addr, 32'hFFFF_FFFC); tick();
  endtask

  // Transaction view: the next fetch address follows program order from the
  // reset PC, a redirect or reset kills whatever is in flight or held, and each
  // surviving fetch is delivered exactly once with memory's word for its PC.
  task automatic random_run();
    logic [31:0] model_pc  = 32'h0;
    logic        prev_rst  = 1'b1;
    logic        mem_pend  = 1'b0;
    int          mem_cnt   = 0;
    logic [31:0] mem_addr  = 32'h0;
    int          deliveries = 0;
    int          gap       = 0;
    logic        fire;
    do_reset();
    exp_q.delete();
    for (int c = 0; c < 3000; c++) begin
      if (mem_pend && mem_cnt > 0) mem_cnt--;
      rst    = ($urandom_range(0, 249) == 0);
      br     = !prev_rst && ($urandom_range(0, 9) == 0);
      tgt    = $urandom();
      rq_rdy = ($urandom_range(0, 3) != 0);
      ir     = ($urandom_range(0, 1) == 1);
      rsp_v  = mem_pend && (mem_cnt == 0);
      rsp_d  = rsp_v ? mem_word(mem_addr) : $urandom();
      if (!mem_pend && $urandom_range(0, 7) == 0) rsp_v = 1'b1;
      @(negedge clk);
      fire = reqv && rq_rdy;
      if (rst) begin
        exp_q.delete();
        model_pc = 32'h0;
        gap = 0;
      end else begin
        if (prev_rst) begin
          chk("rnd_post_reset_iv", 32'(iv), 32'h0);
          chk("rnd_post_reset_reqv", 32'(reqv), 32'h0);
          chk("rnd_post_reset_addr", addr, 32'h0);
        end
        if (br) chk("rnd_req_during_branch", 32'(reqv), 32'h0);
        if (reqv) chk("rnd_one_outstanding", 32'(exp_q.size()), 32'h0);
        chk("rnd_valid_needs_fetch", 32'(iv && exp_q.size() == 0), 32'h0);
        if (fire) chk("rnd_req_addr", addr, model_pc);
        if (iv && exp_q.size() > 0) begin
          chk("rnd_instr_pc", ipc, exp_q[0][63:32]);
          chk("rnd_instr_data", io, exp_q[0][31:0]);
        end
        if (br) begin
          exp_q.delete();
          model_pc = tgt & ~32'h3;
        end else begin
          if (iv && ir && exp_q.size() > 0) begin
            void'(exp_q.pop_front());
            deliveries++;
          end
          if (fire) begin
            exp_q.push_back({model_pc, mem_word(model_pc)});
            model_pc += 32'h4;
          end
        end
        gap = fire ? 0 : gap + 1;
        if (gap > 60) begin
          n_checks++;
          n_fail++;
          $display("FAIL rnd_watchdog: no request accepted for %0d cycles (limit 60)", gap);
          gap = 0;
        end
      end
      if (mem_pend && mem_cnt == 0 && rsp_v) mem_pend = 1'b0;
      if (fire && !rst) begin
        mem_pend = 1'b1;
        mem_cnt  = $urandom_range(1, 3);
        mem_addr = addr;
      end
      if (rst) mem_pend = 1'b0;
      prev_rst = rst;
      tick();
    end
    n_checks++;
    if (deliveries < 100) begin
      n_fail++;
      $display("FAIL rnd_deliveries: got %0d instructions delivered, required at least 100", deliveries);
    end
  endtask

  initial begin
    drv(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    run_table();
    redirect_seq();
    wrap_seq();
    random_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage of the RISC-V core. Holds the program counter and issues one instruction-memory request at a time. It presents each fetched instruction and its PC to decode through a valid/ready handshake. The redirect input (branchTaken/branchTarget) comes from the next-PC select mux in execute; the block owns the PC register downstream of that mux and the memory handshake.

Parameters:
ADDR_WIDTH, 32, width of PC and memory address
INSTR_WIDTH, 32, width of instruction word
RESET_PC, 0, PC loaded on reset (word aligned)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
branchTaken  input  1  redirect request from execute, one-cycle pulse or level
branchTarget  input  ADDR_WIDTH  redirect address; bits [1:0] ignored, forced to 0
imemReqValid  output  1  fetch request valid
imemReqReady  input  1  memory accepts request
imemAddr  output  ADDR_WIDTH  fetch address (current PC)
imemRespValid  input  1  response data valid
imemRespData  input  INSTR_WIDTH  fetched instruction
instrValid  output  1  instruction valid to decode
instrOut  output  INSTR_WIDTH  instruction to decode
instrPc  output  ADDR_WIDTH  PC of instrOut
instrReady  input  1  decode accepts instruction

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Reset (sampled at edge): pc=RESET_PC, reqPc=0, state=IDLE, instrValid=0, instrOut=0, instrPc=0. While reset is high and in IDLE: imemReqValid=0 and imemAddr=RESET_PC.
- imemReqValid = (state==REQ) && !branchTaken, combinational. imemAddr = pc, combinational. instrValid, instrOut and instrPc are registered.
- One outstanding request maximum. The memory returns exactly one response per accepted request, at least 1 cycle after acceptance. The memory is reset by the same reset.
- States: IDLE, REQ, WAIT, HOLD, DROP.
- IDLE: go to REQ next cycle unconditionally.
- REQ:
  - If branchTaken: pc<=branchTarget&~3 and stay REQ; no request is issued this cycle.
  - Else on imemReqValid&&imemReqReady: reqPc<=pc, pc<=pc+4 and go to WAIT.
  - Else stay REQ, holding imemAddr stable.
- WAIT:
  - If branchTaken: pc<=target. If imemRespValid is also high, discard the response and go to REQ; otherwise go to DROP.
  - Else on imemRespValid: instrOut<=imemRespData, instrPc<=reqPc, instrValid<=1, go to HOLD.
- HOLD: instrValid=1; instrOut and instrPc are stable.
  - If branchTaken: instrValid<=0, pc<=target, go to REQ. The held instruction is flushed; branchTaken has priority over instrReady.
  - Else on instrReady: instrValid<=0, go to REQ.
  - Else stay HOLD.
- DROP:
  - If branchTaken: pc<=target and stay DROP.
  - On imemRespValid: discard the data and go to REQ. If branchTaken is also high, pc<=target and go to REQ.
- imemRespValid in IDLE, REQ or HOLD is ignored.
- PC arithmetic: pc+4 modulo 2^ADDR_WIDTH; the wrap from 0x...FFFC gives 0.
- Throughput: at most one instruction per 3 cycles (REQ → WAIT → HOLD), plus memory latency.
- Reset mid-operation discards the held and in-flight instruction. instrValid is 0 on the cycle after the reset edge.

Test Plan:
- Basic fetch, RESET_PC=0, imemReqReady=1, memory latency 1 cycle, data 0x00000013, instrReady=1 → imemReqValid=1 with imemAddr=0 two cycles after reset deasserts. instrValid=1, instrOut=0x00000013, instrPc=0 for one cycle. The next request has imemAddr=0x4.
- Decode stall, instrReady=0 for 5 cycles while HOLD → instrValid, instrOut and instrPc stable and imemReqValid=0 throughout. After instrReady=1, the next imemAddr is the held instrPc+4.
- Memory backpressure, imemReqReady=0 for 3 cycles in REQ → imemReqValid=1 and imemAddr constant. pc advances only on the accepting cycle.
- Redirect in WAIT: request at 0x8 accepted; branchTaken=1 with target 0x103 one cycle before response 0xDEADBEEF → response dropped, instrValid never rises for 0x8. The next request has imemAddr=0x100.
- Redirect coincident with response in WAIT, target 0x200 → data discarded, next imemAddr=0x200. Also covers redirect in HOLD: instrValid drops next cycle even with instrReady=1, and the next imemAddr is the target.
- Wrap and reset: RESET_PC=0xFFFFFFFC → second request imemAddr=0x00000000. Then assert reset while in WAIT → instrValid=0 after the edge, and the next request is at RESET_PC.
